mul_acc: RTL and testbench

Registered accumulate stage that consumes the truncated `DATAWIDTH`-bit products of the datapath multiplier. It sums `TERMS` consecutive products into one frame result and presents that result on a valid/ready output. It sits directly downstream of the multiplier and gives the otherwise purely combinational multiply path its first clocked boundary. Arithmetic wraps modulo 2^`DATAWIDTH`, matching the multiplier. A sticky flag reports lost carries.

---
 rtl/mul_acc.sv | 110 +++++++++++
 tb/tb_mul_acc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_acc.sv
// Accumulates TERMS consecutive multiplier products into one frame sum and
// presents it on a valid/ready output. It also keeps a sticky lost-carry flag.
module mul_acc #(
   parameter int DATAWIDTH = 8,
   parameter int TERMS     = 4
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 clr,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_ovf,
   output logic                 out_valid,
   input  logic                 out_ready
);

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(TERMS - 1);

   state_t                 state_q, state_d;
   logic [DATAWIDTH-1:0]   acc_q, acc_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic [DATAWIDTH-1:0]   out_data_q, out_data_d;
   logic                   out_ovf_q, out_ovf_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATAWIDTH:0]     sum;

   // One extra bit on the adder exposes the carry that the wrapped sum drops.
   always_comb begin
      sum         = {1'b0, acc_q} + {1'b0, in_data};
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q;

      if (clr) begin
         state_d     = ACC;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_data_d  = '0;
         out_ovf_d   = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (in_valid) begin
                  if (cnt_q == LAST_CNT) begin
                     out_data_d  = sum[DATAWIDTH-1:0];
                     out_ovf_d   = ovf_q | sum[DATAWIDTH];
                     out_valid_d = 1'b1;
                     acc_d       = '0;
                     cnt_d       = '0;
                     ovf_d       = 1'b0;
                     state_d     = HOLD;
                  end else begin
                     acc_d = sum[DATAWIDTH-1:0];
                     ovf_d = ovf_q | sum[DATAWIDTH];
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = ACC;
               end
            end
            default: state_d = ACC;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Ready depends only on registered state, so out_ready never ripples upstream.
   assign in_ready  = (state_q == ACC);
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mul_acc.sv
// Directed bench for mul_acc: a TERMS=4 instance for frame behaviour and a
// TERMS=1 instance for the single-term pass-through case.
module tb_mul_acc;

   logic       Clk;
   logic       Rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       clr;
   logic [7:0] out_data;
   logic       out_ovf;
   logic       out_valid;
   logic       out_ready;

   logic [7:0] in_data1;
   logic       in_valid1;
   logic       in_ready1;
   logic       clr1;
   logic [7:0] out_data1;
   logic       out_ovf1;
   logic       out_valid1;
   logic       out_ready1;

   int errors = 0;
   int checks = 0;

   mul_acc #(.DATAWIDTH(8), .TERMS(4)) dut (
      .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .clr(clr), .out_data(out_data), .out_ovf(out_ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   mul_acc #(.DATAWIDTH(8), .TERMS(1)) dut1 (
      .Clk(Clk), .Rst(Rst), .in_data(in_data1), .in_valid(in_valid1),
      .in_ready(in_ready1), .clr(clr1), .out_data(out_data1), .out_ovf(out_ovf1),
      .out_valid(out_valid1), .out_ready(out_ready1)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Advance one edge and settle; inputs set afterwards apply at the next edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      step();
      step();
      Rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", in_ready); end
      checks++;
      if (out_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_data: got %0d expected 0", out_data); end
      checks++;
      if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b expected 0", out_ovf); end
      checks++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_t1: got valid=%0b ready=%0b expected valid=0 ready=1", out_valid1, in_ready1);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      push(8'd1);
      push(8'd2);
      push(8'd3);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_early: got valid=%0b ready=%0b expected valid=0 ready=1", out_valid, in_ready);
      end
      push(8'd4);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0b expected 1", out_valid); end
      checks++;
      if (out_data !== 8'd10) begin errors++; $display("[TB] FAIL basic_data: got %0d expected 10", out_data); end
      checks++;
      if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %0b expected 0", out_ovf); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_hold_ready: got %0b expected 0", in_ready); end
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_return: got ready=%0b valid=%0b expected ready=1 valid=0", in_ready, out_valid);
      end
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(8'd100);
      checks++;
      if (out_data !== 8'd144 || out_ovf !== 1'b1 || out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL wrap_result: got data=%0d ovf=%0b valid=%0b expected data=144 ovf=1 valid=1", out_data, out_ovf, out_valid);
      end
      step();
      for (int i = 0; i < 4; i++) push(8'd1);
      checks++;
      if (out_data !== 8'd4 || out_ovf !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL wrap_sticky_clear: got data=%0d ovf=%0b valid=%0b expected data=4 ovf=0 valid=1", out_data, out_ovf, out_valid);
      end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push(8'd10);
      push(8'd20);
      push(8'd30);
      push(8'd40);
      in_valid = 1'b1;
      in_data  = 8'd7;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'd100 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d: got valid=%0b data=%0d ovf=%0b ready=%0b expected valid=1 data=100 ovf=0 ready=0",
                     i, out_valid, out_data, out_ovf, in_ready);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL bp_release: got ready=%0b valid=%0b expected ready=1 valid=0", in_ready, out_valid);
      end
      step();
      in_valid = 1'b0;
      push(8'd1);
      push(8'd1);
      push(8'd1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd10) begin
         errors++; $display("[TB] FAIL bp_held_term: got valid=%0b data=%0d expected valid=1 data=10", out_valid, out_data);
      end
      step();
   endtask

   task automatic test_gaps();
      out_ready = 1'b1;
      push(8'd5);
      step();
      step();
      push(8'd6);
      step();
      push(8'd7);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL gaps_early: got valid=%0b ready=%0b expected valid=0 ready=1", out_valid, in_ready);
      end
      push(8'd8);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd26 || out_ovf !== 1'b0) begin
         errors++; $display("[TB] FAIL gaps_result: got valid=%0b data=%0d ovf=%0b expected valid=1 data=26 ovf=0", out_valid, out_data, out_ovf);
      end
      step();
   endtask

   task automatic test_clear_reset();
      out_ready = 1'b1;
      push(8'd9);
      push(8'd9);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd50;
      step();
      clr      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0) begin
         errors++; $display("[TB] FAIL clr_state: got ready=%0b valid=%0b data=%0d expected ready=1 valid=0 data=0", in_ready, out_valid, out_data);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'd2);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd8) begin
         errors++; $display("[TB] FAIL clr_after: got valid=%0b data=%0d expected valid=1 data=8", out_valid, out_data);
      end
      Rst       = 1'b1;
      out_ready = 1'b1;
      step();
      Rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'd0) begin
         errors++; $display("[TB] FAIL rst_in_hold: got valid=%0b ready=%0b data=%0d expected valid=0 ready=1 data=0", out_valid, in_ready, out_data);
      end
      // A clear while a result is held must drop it entirely.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'd3);
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'd0) begin
         errors++; $display("[TB] FAIL clr_in_hold: got valid=%0b ready=%0b data=%0d expected valid=0 ready=1 data=0", out_valid, in_ready, out_data);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_single_term();
      int results;
      results    = 0;
      out_ready1 = 1'b1;
      in_valid1  = 1'b1;
      in_data1   = 8'hFF;
      step();
      checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== 8'hFF || out_ovf1 !== 1'b0 || in_ready1 !== 1'b0) begin
         errors++; $display("[TB] FAIL t1_first: got valid=%0b data=%0h ovf=%0b ready=%0b expected valid=1 data=ff ovf=0 ready=0",
                            out_valid1, out_data1, out_ovf1, in_ready1);
      end
      step();
      checks++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
         errors++; $display("[TB] FAIL t1_return: got valid=%0b ready=%0b expected valid=0 ready=1", out_valid1, in_ready1);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid1 === 1'b1) results++;
      end
      checks++;
      if (results !== 4) begin errors++; $display("[TB] FAIL t1_rate: got %0d results expected 4", results); end
      in_valid1 = 1'b0;
   endtask

   initial begin
      Rst        = 1'b1;
      clr        = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'd0;
      out_ready  = 1'b0;
      clr1       = 1'b0;
      in_valid1  = 1'b0;
      in_data1   = 8'd0;
      out_ready1 = 1'b0;
      $display("[TB] starting mul_acc bench");
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_gaps();
      test_clear_reset();
      test_single_term();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
